// File: rtl/twiddle_gen.sv
// Streaming radix-2 FFT twiddle generator: quarter-wave cosine ROM, symmetry reconstruction, valid/ready output.
// Optional macro TWIDDLE_INV_EN adds the 'inv' port for conjugate (IFFT) twiddles.
module twiddle_gen #(
    parameter int LOG2N = 6,
    parameter int FRAC  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(LOG2N)-1:0]   stage,
    output logic                       busy,
    output logic                       tw_valid,
    input  logic                       tw_ready,
    output logic signed [FRAC+1:0]     tw_re,
    output logic signed [FRAC+1:0]     tw_im,
    output logic [LOG2N-2:0]           tw_idx,
    output logic                       tw_last
`ifdef TWIDDLE_INV_EN
    ,
    input  logic                       inv
`endif
);

    localparam int W  = FRAC + 2;
    localparam int N  = 1 << LOG2N;
    localparam int Q  = N / 4;
    localparam int JW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);
    localparam logic [JW-1:0] QV = JW'(Q);

    localparam longint PI_FX  = 64'sd3373259426;
    localparam longint ONE_FX = 64'sd1073741824;

    // Cosine in 2.30 fixed point by Taylor series, so the table needs no real arithmetic at elaboration.
    function automatic logic [(Q+1)*W-1:0] buildRom();
        logic [(Q+1)*W-1:0] rom;
        longint x, x2, term, sum, v;
        rom = '0;
        for (int m = 0; m <= Q; m++) begin
            x    = (2 * PI_FX * m) / N;
            x2   = (x * x) >>> 30;
            term = ONE_FX;
            sum  = ONE_FX;
            for (int k = 1; k <= 14; k++) begin
                term = -((term * x2) >>> 30) / longint'((2 * k - 1) * (2 * k));
                sum  = sum + term;
            end
            v = ((sum <<< FRAC) + (ONE_FX >>> 1)) >>> 30;
            if (v < 0) v = 0;
            rom[m*W +: W] = v[W-1:0];
        end
        return rom;
    endfunction

    localparam logic [(Q+1)*W-1:0] ROM_FLAT = buildRom();

    typedef enum logic {IDLE, RUN} state_t;

    state_t                r_state;
    logic                  r_busy;
    logic [SW-1:0]         r_stage;
    logic [JW-1:0]         r_cnt;
    logic [JW-1:0]         r_cntMax;
    logic                  r_issue;
    logic                  r_inv;
    logic                  r_s1Valid;
    logic                  r_s1Last;
    logic                  r_s1Hi;
    logic [JW-1:0]         r_s1J;
    logic [W-1:0]          r_s1ReMag;
    logic [W-1:0]          r_s1ImMag;
    logic                  r_outValid;
    logic                  r_outLast;
    logic [JW-1:0]         r_outJ;
    logic signed [W-1:0]   r_outRe;
    logic signed [W-1:0]   r_outIm;

    logic [W-1:0]          w_rom [0:Q];
    logic [JW-1:0]         w_j;
    logic                  w_jHi;
    logic [JW-1:0]         w_addrRe;
    logic [JW-1:0]         w_addrIm;
    logic [JW-1:0]         w_newMax;
    logic                  w_accept;
    logic                  w_stall;
    logic                  w_adv;
    logic                  w_issue;
    logic                  w_lastIssue;
    logic                  w_done;
    logic                  w_invIn;
    logic signed [W-1:0]   w_re;
    logic signed [W-1:0]   w_im;

    for (genvar m = 0; m <= Q; m++) begin : g_rom
        assign w_rom[m] = ROM_FLAT[m*W +: W];
    end

`ifdef TWIDDLE_INV_EN
    assign w_invIn = inv;
`else
    assign w_invIn = 1'b0;
`endif

    // Upper half of the half-circle mirrors about Q; 0 - j wraps to 2Q - j in JW bits.
    assign w_j         = r_cnt << r_stage;
    assign w_jHi       = (w_j >= QV);
    assign w_addrRe    = w_jHi ? (JW'(0) - w_j) : w_j;
    assign w_addrIm    = w_jHi ? (w_j - QV) : (QV - w_j);
    assign w_newMax    = JW'((N >> (int'(stage) + 1)) - 1);
    assign w_accept    = (r_state == IDLE) && start && (int'(stage) < LOG2N);
    assign w_stall     = r_outValid && !tw_ready;
    assign w_adv       = !w_stall;
    assign w_issue     = (r_state == RUN) && r_issue && w_adv;
    assign w_lastIssue = (r_cnt == r_cntMax);
    assign w_done      = r_outValid && tw_ready && r_outLast;
    assign w_re        = r_s1Hi ? -$signed(r_s1ReMag) : $signed(r_s1ReMag);
    assign w_im        = r_inv ? $signed(r_s1ImMag) : -$signed(r_s1ImMag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_stage    <= '0;
            r_cnt      <= '0;
            r_cntMax   <= '0;
            r_issue    <= 1'b0;
            r_inv      <= 1'b0;
            r_s1Valid  <= 1'b0;
            r_s1Last   <= 1'b0;
            r_s1Hi     <= 1'b0;
            r_s1J      <= '0;
            r_s1ReMag  <= '0;
            r_s1ImMag  <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outJ     <= '0;
            r_outRe    <= '0;
            r_outIm    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                        r_stage  <= stage;
                        r_cnt    <= '0;
                        r_cntMax <= w_newMax;
                        r_issue  <= 1'b1;
                        r_inv    <= w_invIn;
                    end
                end
                RUN: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_issue) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_lastIssue) r_issue <= 1'b0;
            end

            // Both pipeline stages move together; a held output freezes everything behind it.
            if (w_adv) begin
                r_s1Valid <= w_issue;
                if (w_issue) begin
                    r_s1J     <= w_j;
                    r_s1Hi    <= w_jHi;
                    r_s1Last  <= w_lastIssue;
                    r_s1ReMag <= w_rom[w_addrRe];
                    r_s1ImMag <= w_rom[w_addrIm];
                end
                r_outValid <= r_s1Valid;
                r_outLast  <= r_s1Valid && r_s1Last;
                if (r_s1Valid) begin
                    r_outJ  <= r_s1J;
                    r_outRe <= w_re;
                    r_outIm <= w_im;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign tw_valid = r_outValid;
    assign tw_last  = r_outLast;
    assign tw_idx   = r_outJ;
    assign tw_re    = r_outRe;
    assign tw_im    = r_outIm;

endmodule

// File: tb/tb_twiddle_gen.sv
// Self-checking bench for twiddle_gen: constant vectors from known twiddle values plus randomized
// stage runs with a toggling tw_ready, checked against a direct cos/sin reference.
`timescale 1ns/1ps
module tb_twiddle_gen;

    localparam int  LOG2N = 6;
    localparam int  FRAC  = 8;
    localparam int  W     = FRAC + 2;
    localparam int  N     = 1 << LOG2N;
    localparam real PI    = 3.14159265358979323846;
`ifdef TWIDDLE_INV_EN
    localparam bit  INV_EN = 1'b1;
`else
    localparam bit  INV_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [2:0]          stage = 3'd0;
    logic                twReady = 1'b1;
    logic                inv = 1'b0;
    logic                busy;
    logic                twValid;
    logic signed [W-1:0] twRe;
    logic signed [W-1:0] twIm;
    logic [LOG2N-2:0]    twIdx;
    logic                twLast;

    int checks = 0;
    int errors = 0;
    int capIdx[$];
    int capRe[$];
    int capIm[$];
    int capLast[$];
    bit prevStall = 1'b0;
    int prevRe, prevIm, prevIdx, prevLast;

    typedef struct {
        int stg;
        int j;
        int expRe;
        int expIm;
    } vec_t;
    vec_t vecs[8];

    twiddle_gen #(.LOG2N(LOG2N), .FRAC(FRAC)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stage    (stage),
        .busy     (busy),
        .tw_valid (twValid),
        .tw_ready (twReady),
        .tw_re    (twRe),
        .tw_im    (twIm),
        .tw_idx   (twIdx),
        .tw_last  (twLast)
`ifdef TWIDDLE_INV_EN
        ,
        .inv      (inv)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic failTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual timeout required completion", name);
    endtask

    function automatic int roundAway(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    function automatic int refRe(input int j);
        return roundAway(real'(1 << FRAC) * $cos(2.0 * PI * j / N));
    endfunction

    function automatic int refIm(input int j, input bit iv);
        int v;
        v = roundAway(-real'(1 << FRAC) * $sin(2.0 * PI * j / N));
        return iv ? -v : v;
    endfunction

    // Records every transfer and checks that a stalled output does not move.
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_valid", twValid, 1);
                checkOutput("stall_re", twRe, prevRe);
                checkOutput("stall_im", twIm, prevIm);
                checkOutput("stall_idx", twIdx, prevIdx);
                checkOutput("stall_last", twLast, prevLast);
            end
            if (twValid && twReady) begin
                capIdx.push_back(int'(twIdx));
                capRe.push_back(int'(twRe));
                capIm.push_back(int'(twIm));
                capLast.push_back(int'(twLast));
            end
            prevStall = twValid && !twReady;
            prevRe    = twRe;
            prevIm    = twIm;
            prevIdx   = twIdx;
            prevLast  = twLast;
        end
    end

    task automatic clearCapture();
        capIdx.delete();
        capRe.delete();
        capIm.delete();
        capLast.delete();
    endtask

    task automatic checkCap(input string nm, input int k, input int expIdx, input int expRe, input int expIm);
        if (k >= capIdx.size()) begin
            checkOutput({nm, "_present"}, capIdx.size(), k + 1);
        end else begin
            checkOutput({nm, "_idx"}, capIdx[k], expIdx);
            checkOutput({nm, "_re"}, capRe[k], expRe);
            checkOutput({nm, "_im"}, capIm[k], expIm);
        end
    endtask

    task automatic verifySequence(input int s, input bit iv);
        int m;
        int j;
        m = N >> (s + 1);
        checkOutput($sformatf("count_s%0d", s), capIdx.size(), m);
        for (int k = 0; k < m && k < capIdx.size(); k++) begin
            j = k << s;
            checkCap($sformatf("seq_s%0d_k%0d", s, k), k, j, refRe(j), refIm(j, iv));
            checkOutput($sformatf("seq_s%0d_k%0d_last", s, k), capLast[k], (k == m - 1) ? 1 : 0);
        end
    endtask

    // One full stage run; with randReady the consumer stalls randomly and stray starts are thrown in.
    task automatic applyStimulus(input int s, input bit randReady, input bit iv);
        int cyc;
        clearCapture();
        @(posedge clk); #1;
        start   = 1'b1;
        stage   = 3'(s);
        inv     = iv;
        twReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        if (!randReady) begin
            checkOutput("valid_lat0", twValid, 0);
            @(posedge clk); #1;
            checkOutput("valid_lat1", twValid, 0);
            @(posedge clk); #1;
            checkOutput("valid_lat2", twValid, 1);
            checkOutput("idx_first", twIdx, 0);
        end
        cyc = 0;
        while (busy && cyc < 3000) begin
            if (randReady) begin
                twReady = 1'($urandom_range(0, 1));
                start   = 1'($urandom_range(0, 1));
                stage   = 3'($urandom_range(0, 5));
                inv     = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        start   = 1'b0;
        twReady = 1'b1;
        if (busy) failTimeout($sformatf("busy_s%0d", s));
        checkOutput("valid_after_done", twValid, 0);
        verifySequence(s, iv);
    endtask

    initial begin
        int ranStage;
        int cyc;
        bit found;
        bit iv;

        vecs[0] = '{0, 0, 256, 0};
        vecs[1] = '{0, 8, 181, -181};
        vecs[2] = '{0, 16, 0, -256};
        vecs[3] = '{0, 17, -25, -255};
        vecs[4] = '{0, 31, -255, -25};
        vecs[5] = '{2, 4, 237, -98};
        vecs[6] = '{2, 20, -98, -237};
        vecs[7] = '{5, 0, 256, 0};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_valid", twValid, 0);
        checkOutput("reset_re", twRe, 0);
        checkOutput("reset_im", twIm, 0);
        checkOutput("reset_idx", twIdx, 0);
        checkOutput("reset_last", twLast, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int s = 6; s <= 7; s++) begin
            start = 1'b1;
            stage = 3'(s);
            @(posedge clk); #1;
            start = 1'b0;
            checkOutput($sformatf("bad_stage%0d_busy", s), busy, 0);
            repeat (3) @(posedge clk);
            #1;
            checkOutput($sformatf("bad_stage%0d_valid", s), twValid, 0);
            checkOutput($sformatf("bad_stage%0d_busy_late", s), busy, 0);
        end

        ranStage = -1;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].stg != ranStage) begin
                applyStimulus(vecs[i].stg, 1'b0, 1'b0);
                ranStage = vecs[i].stg;
            end
            checkCap($sformatf("vec%0d", i), vecs[i].j >> vecs[i].stg, vecs[i].j, vecs[i].expRe, vecs[i].expIm);
        end
        checkOutput("vec_s5_last", (capLast.size() > 0) ? capLast[0] : -1, 1);

        applyStimulus(0, 1'b1, 1'b0);

        repeat (6) begin
            iv = INV_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            applyStimulus($urandom_range(0, 5), 1'b1, iv);
        end

        clearCapture();
        @(posedge clk); #1;
        start   = 1'b1;
        stage   = 3'd0;
        inv     = 1'b0;
        twReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        found = 1'b0;
        while (!found && cyc < 200) begin
            @(negedge clk);
            if (twValid && twIdx == 10) found = 1'b1;
            cyc++;
        end
        if (!found) failTimeout("reach_k10");
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_valid", twValid, 0);
        checkOutput("midrst_re", twRe, 0);
        checkOutput("midrst_idx", twIdx, 0);
        checkOutput("midrst_last", twLast, 0);
        @(negedge clk);
        checkOutput("midrst_busy_held", busy, 0);
        checkOutput("midrst_valid_held", twValid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1, 1'b0, 1'b0);

        if (INV_EN) begin
            applyStimulus(0, 1'b0, 1'b1);
            checkCap("inv_j16", 16, 16, 0, 256);
            checkCap("inv_j17", 17, 17, -25, 255);
            applyStimulus(0, 1'b0, 1'b0);
            checkCap("fwd_j16", 16, 16, 0, -256);
            checkCap("fwd_j17", 17, 17, -25, -255);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
